wait_memory: RTL and testbench
==============================

# wait_memory

Parametrised synchronous RAM with a request/acknowledge handshake, programmable wait states and byte-lane write enables. It is the next generation of the VeriRISC single-port memory. It replaces the bidirectional `data` bus with separate write and read buses, so the controller can model slow memory and sub-word stores. It sits between the controller/ALU datapath and the instruction/data store.

## Interface
- `AWIDTH`, default 5: address width; depth = 2**AWIDTH words.
- `DWIDTH`, default 8: word width; must be a multiple of 8.
- `WAIT`, default 1: wait states per access, legal range 0..15.
- `LANES`, default DWIDTH/8: derived localparam; number of byte lanes.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, 1: access request; sampled only when `busy`=0.
- `we`, input, 1: 1 = write, 0 = read; qualified by `req`.
- `addr`, input, AWIDTH: word address.
- `wdata`, input, DWIDTH: write data.
- `be`, input, LANES: byte enables; lane i covers bits [8i+7:8i]; ignored on reads.
- `rdata`, output, DWIDTH: registered read data.
- `ack`, output, 1: one-cycle pulse marking completion of the accepted access.
- `busy`, output, 1: high while an access is in flight; requests are ignored while high.

## Operation
- FSM states are IDLE and WAITING.
- IDLE:
  - On a rising edge with `req`=1, capture `addr`, `we`, `wdata` and `be` into holding registers. Later changes on the inputs have no effect on the accepted access.
  - If `WAIT`=0, perform the access at this same edge, pulse `ack` next cycle and stay in IDLE.
  - Otherwise, load the wait counter with `WAIT`-1 and go to WAITING.
- WAITING:
  - `busy`=1.
  - The counter decrements each edge.
  - At the edge where the counter is 0, perform the access, assert `ack` and return to IDLE.
- Access:
  - Write: each lane with `be`[i]=1 is updated; lanes with `be`[i]=0 keep their old value. A write with `be`=0 still completes and acks. `rdata` is unchanged by writes.
  - Read: `rdata` loads mem[addr] at the access edge and holds until the next read completes.
- `ack` is high for exactly one cycle per accepted request. During that cycle `busy`=0 and the FSM is in IDLE, so a new `req` in the `ack` cycle is accepted.
- Every address 0..2**AWIDTH-1 is valid; there is no out-of-range case.
- Memory contents are not initialised and are not cleared by `rst`.
- Holding registers and the counter are not reset-critical; only the FSM, `ack`, `busy` and `rdata` reset.

## Timing
- Reset values: `ack`=0, `busy`=0, `rdata`=0, FSM in IDLE, counter=0.
- Reset mid-access aborts the access. A write whose access edge has not yet occurred is not committed. No `ack` follows.
- `rst` and `req` high on the same edge: reset wins and the request is dropped.
- Latency: `req` is sampled at edge E0, and `ack` is high in the cycle after edge E0+`WAIT`. That gives `WAIT`+1 cycles from the sample edge to `ack`.
- `rdata` is valid in the same cycle as `ack` and stays stable afterwards.
- `busy` rises the cycle after acceptance, and only when `WAIT`>=1. It falls in the `ack` cycle.
- Peak throughput is one access per `WAIT`+1 cycles. With `WAIT`=0 it is one access per cycle, and `busy` stays 0.
- A read to the address written by the immediately preceding access returns the new data.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles → `ack`=0, `busy`=0, `rdata`=0. Assert `rst` in the middle of a write to address 3 with `WAIT`=3, then read address 3 → old value, and no `ack` for the aborted write.
- **Fill and readback** (default params, `WAIT`=1):
  - Write data 0,1,2… descending from address 31 to address 1 → each `ack` arrives 2 cycles after the sample edge.
  - Read back in the same order → `rdata` = 0,1,2… in the `ack` cycles.
- **Byte lanes** (`DWIDTH`=32):
  - Write 0xAABBCCDD to address 5 with `be`=4'b1111.
  - Then write 0x11223344 with `be`=4'b0101.
  - Read address 5 → 0xAA22CC44.
- **Wait-state sweep:** run with `WAIT`=0, 3 and 15; read at address 7 → `ack` exactly 1, 4 and 16 cycles after the sample edge. `busy` is high for 0, 3 and 15 cycles respectively.
- **Busy and back-to-back:**
  - With `WAIT`=2, hold `req`=1 with a different address during `busy` → that request is ignored.
  - A request presented in the `ack` cycle is accepted, and the next `ack` comes 3 cycles later.
- **Write/read ordering:**
  - Write 0x5A to address 0, then immediately read address 0 → 0x5A.
  - A write with `be`=0 to address 0 → acks, and the contents remain 0x5A.

Source files
------------

// File: rtl/wait_memory.sv
// Single-port RAM with req/ack handshake, WAIT programmable wait states and byte-lane writes.
// An accepted request completes WAIT+1 cycles after its sample edge. New requests are ignored while busy_o is high.
module wait_memory #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8,
   parameter int WAIT   = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [AWIDTH-1:0]     addr_i,
   input  logic [DWIDTH-1:0]     wdata_i,
   input  logic [DWIDTH/8-1:0]   be_i,
   output logic [DWIDTH-1:0]     rdata_o,
   output logic                  ack_o,
   output logic                  busy_o
);

   localparam int LANES = DWIDTH / 8;
   localparam int DEPTH = 2 ** AWIDTH;
   localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

   typedef enum logic {IDLE, WAITING} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                ack_q, ack_d;
   logic [DWIDTH-1:0]   rdata_q;

   logic [AWIDTH-1:0]   addr_q;
   logic                we_q;
   logic [DWIDTH-1:0]   wdata_q;
   logic [LANES-1:0]    be_q;

   logic                capture;
   logic                acc_vld;
   logic                acc_we;
   logic [AWIDTH-1:0]   acc_addr;
   logic [DWIDTH-1:0]   acc_wdata;
   logic [LANES-1:0]    acc_be;

   logic [DWIDTH-1:0]   mem_q [DEPTH];

   // With zero wait states the access uses the live inputs on the acceptance edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture   = 1'b0;
      acc_vld   = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               capture = 1'b1;
               if (WAIT == 0) begin
                  acc_vld   = 1'b1;
                  acc_we    = we_i;
                  acc_addr  = addr_i;
                  acc_wdata = wdata_i;
                  acc_be    = be_i;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = WAITING;
               end
            end
         end
         WAITING: begin
            if (cnt_q == 4'd0) begin
               acc_vld = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      ack_d = acc_vld;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         if (acc_vld && !acc_we) begin
            rdata_q <= mem_q[acc_addr];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (capture) begin
         addr_q  <= addr_i;
         we_q    <= we_i;
         wdata_q <= wdata_i;
         be_q    <= be_i;
      end
   end

   // A reset landing on the access edge must not commit the write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && acc_vld && acc_we) begin
         for (int i = 0; i < LANES; i++) begin
            if (acc_be[i]) begin
               mem_q[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;
   assign ack_o   = ack_q;
   assign busy_o  = (state_q == WAITING);

endmodule

// File: tb/tb_wait_memory.sv
// Bench for wait_memory: five instances with different WAIT/DWIDTH, a queue scoreboard and a word/lane reference memory.
module tb_wait_memory;

   localparam int NDUT = 5;

   function automatic int wt_of(input int k);
      case (k)
         0: return 0;
         1: return 1;
         2: return 2;
         3: return 3;
         default: return 15;
      endcase
   endfunction

   function automatic int dw_of(input int k);
      return (k == 1) ? 8 : 32;
   endfunction

   typedef struct {
      int          k;
      int          exp_cyc;
      bit          is_rd;
      logic [31:0] d;
      logic [31:0] m;
   } exp_t;

   logic        clk;
   logic [4:0]  rst, req, we, ack, busy;
   logic [4:0]  addr  [NDUT];
   logic [31:0] wdata [NDUT];
   logic [31:0] rdata [NDUT];
   logic [3:0]  be    [NDUT];

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 1'b0;
   exp_t        sbq[$];

   logic [31:0] refmem   [NDUT][32];
   logic [31:0] refknown [NDUT][32];
   logic [31:0] lastrd [NDUT];
   logic [31:0] lastm  [NDUT];
   bit          act  [NDUT];
   int          acc0 [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : gd
      localparam int DW = dw_of(g);
      localparam int LN = DW / 8;
      logic [DW-1:0] rd;
      wait_memory #(.AWIDTH(5), .DWIDTH(DW), .WAIT(wt_of(g))) u_dut (
         .clk_i   (clk),
         .rst_i   (rst[g]),
         .req_i   (req[g]),
         .we_i    (we[g]),
         .addr_i  (addr[g]),
         .wdata_i (wdata[g][DW-1:0]),
         .be_i    (be[g][LN-1:0]),
         .rdata_o (rd),
         .ack_o   (ack[g]),
         .busy_o  (busy[g])
      );
      assign rdata[g] = 32'(rd);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: cycle %0d reached, required completion earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int k, input logic [31:0] a,
                      input logic [31:0] e, input logic [31:0] m);
      n_cmp++;
      if (((a ^ e) & m) !== 32'd0) begin
         n_bad++;
         $display("FAIL %s dut%0d cyc%0d: got %h required %h (mask %h)", nm, k, cyc, a, e, m);
      end
   endtask

   function automatic logic [31:0] lane_mask(input int k, input logic [3:0] b);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         if (b[i] && i < dw_of(k) / 8) m[8*i +: 8] = 8'hFF;
      end
      return m;
   endfunction

   // Drives one request for one sample edge; on return the caller sits #1 after that edge.
   task automatic issue(input int k, input bit w, input int a, input logic [31:0] d,
                        input logic [3:0] b, input bit commit);
      logic [31:0] m;
      exp_t        e;
      int          e0;
      req[k] = 1'b1; we[k] = w; addr[k] = 5'(a); wdata[k] = d; be[k] = b;
      @(posedge clk); #1;
      e0 = cyc;
      req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = 5'($urandom);
      wdata[k] = $urandom; be[k] = 4'($urandom);
      act[k] = 1'b1;
      acc0[k] = e0;
      if (commit) begin
         e.k = k; e.exp_cyc = e0 + wt_of(k); e.is_rd = !w; e.d = '0; e.m = '0;
         if (w) begin
            m = lane_mask(k, b);
            refmem[k][a]   = (refmem[k][a] & ~m) | (d & m);
            refknown[k][a] = refknown[k][a] | m;
         end else begin
            e.d = refmem[k][a];
            e.m = refknown[k][a];
         end
         sbq.push_back(e);
      end
   endtask

   task automatic wait_done(input int k);
      for (int i = 0; i < 40 && act[k]; i++) @(posedge clk);
      #1;
   endtask

   task automatic to_ack_cycle(input int k);
      if (wt_of(k) > 0) begin
         repeat (wt_of(k)) @(posedge clk);
         #1;
      end
   endtask

   // Monitor: checks busy every cycle, pops the scoreboard on ack, checks rdata holds otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         for (int k = 0; k < NDUT; k++) begin
            chk("busy", k, 32'(busy[k]),
                32'(act[k] && cyc >= acc0[k] && cyc < acc0[k] + wt_of(k)), 32'h1);
            if (ack[k] === 1'b1) begin
               if (sbq.size() == 0 || sbq[0].k != k) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_ack dut%0d cyc%0d: got ack=1 required ack=0", k, cyc);
               end else begin
                  e = sbq.pop_front();
                  act[k] = 1'b0;
                  chk("ack_cycle", k, 32'(cyc), 32'(e.exp_cyc), 32'hFFFF_FFFF);
                  if (e.is_rd) begin
                     if (e.m != 0) chk("rdata", k, rdata[k], e.d, e.m);
                     lastrd[k] = e.d;
                     lastm[k]  = e.m;
                  end else if (lastm[k] != 0) begin
                     chk("rdata_hold", k, rdata[k], lastrd[k], lastm[k]);
                  end
               end
            end else if (lastm[k] != 0) begin
               chk("rdata_hold", k, rdata[k], lastrd[k], lastm[k]);
            end
         end
         if (sbq.size() > 0 && cyc > sbq[0].exp_cyc) begin
            e = sbq.pop_front();
            act[e.k] = 1'b0;
            n_cmp++; n_bad++;
            $display("FAIL missing_ack dut%0d cyc%0d: got no ack required ack at cyc%0d", e.k, cyc, e.exp_cyc);
         end
      end
   end

   initial begin
      rst = '1; req = '0; we = '0;
      for (int k = 0; k < NDUT; k++) begin
         addr[k] = '0; wdata[k] = '0; be[k] = '0;
         act[k] = 1'b0; acc0[k] = 0; lastrd[k] = '0; lastm[k] = '0;
         for (int a = 0; a < 32; a++) begin
            refmem[k][a] = '0; refknown[k][a] = '0;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      rst = '0;
      for (int k = 0; k < NDUT; k++) begin
         chk("reset_ack", k, 32'(ack[k]), 32'd0, 32'h1);
         chk("reset_busy", k, 32'(busy[k]), 32'd0, 32'h1);
         chk("reset_rdata", k, rdata[k], 32'd0, 32'hFFFF_FFFF);
         lastrd[k] = '0;
         lastm[k]  = '1;
      end
      mon_en = 1'b1;

      // Fill descending with 0,1,2... then read back in the same order (WAIT=1, 8-bit).
      for (int i = 0; i < 31; i++) begin
         issue(1, 1'b1, 31 - i, 32'(i), 4'h1, 1'b1);
         wait_done(1);
      end
      for (int i = 0; i < 31; i++) begin
         issue(1, 1'b0, 31 - i, 32'h0, 4'h0, 1'b1);
         wait_done(1);
      end

      // Byte lanes on the 32-bit zero-wait instance, issued back to back.
      issue(0, 1'b1, 5, 32'hAABB_CCDD, 4'b1111, 1'b1);
      issue(0, 1'b1, 5, 32'h1122_3344, 4'b0101, 1'b1);
      issue(0, 1'b0, 5, 32'h0, 4'h0, 1'b1);
      wait_done(0);

      // Wait-state sweep: read address 7 at WAIT 0, 3 and 15.
      for (int j = 0; j < 3; j++) begin
         int k;
         k = (j == 0) ? 0 : (j == 1) ? 3 : 4;
         issue(k, 1'b1, 7, 32'hC0DE_0007 + 32'(k), 4'hF, 1'b1);
         wait_done(k);
         issue(k, 1'b0, 7, 32'h0, 4'h0, 1'b1);
         wait_done(k);
      end

      // Requests held during busy are ignored; a request in the ack cycle is taken.
      issue(2, 1'b1, 20, 32'h2020_2020, 4'hF, 1'b1);
      wait_done(2);
      issue(2, 1'b1, 9, 32'h0909_0909, 4'hF, 1'b1);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 5'd20; wdata[2] = 32'hDEAD_BEEF; be[2] = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      req[2] = 1'b0;
      issue(2, 1'b0, 9, 32'h0, 4'h0, 1'b1);
      wait_done(2);
      issue(2, 1'b0, 20, 32'h0, 4'h0, 1'b1);
      wait_done(2);

      // Reset on the same edge as a write request drops it.
      rst[2] = 1'b1; req[2] = 1'b1; we[2] = 1'b1; addr[2] = 5'd20; wdata[2] = 32'h5555_AAAA; be[2] = 4'hF;
      @(posedge clk); #1;
      rst[2] = 1'b0; req[2] = 1'b0;
      lastrd[2] = '0; lastm[2] = '1;
      issue(2, 1'b0, 20, 32'h0, 4'h0, 1'b1);
      wait_done(2);

      // Reset in the middle of a WAIT=3 write aborts it: no ack, old data kept.
      issue(3, 1'b1, 3, 32'h3333_0003, 4'hF, 1'b1);
      wait_done(3);
      issue(3, 1'b1, 3, 32'hBAD0_BAD0, 4'hF, 1'b0);
      rst[3] = 1'b1;
      @(posedge clk); #1;
      act[3] = 1'b0;
      lastrd[3] = '0; lastm[3] = '1;
      @(posedge clk); #1;
      rst[3] = 1'b0;
      chk("abort_ack", 3, 32'(ack[3]), 32'd0, 32'h1);
      chk("abort_busy", 3, 32'(busy[3]), 32'd0, 32'h1);
      chk("abort_rdata", 3, rdata[3], 32'd0, 32'hFFFF_FFFF);
      repeat (6) @(posedge clk);
      #1;
      issue(3, 1'b0, 3, 32'h0, 4'h0, 1'b1);
      wait_done(3);

      // Write then read in the ack cycle; a be=0 write leaves the word alone.
      issue(1, 1'b1, 0, 32'h5A, 4'h1, 1'b1);
      to_ack_cycle(1);
      issue(1, 1'b0, 0, 32'h0, 4'h0, 1'b1);
      wait_done(1);
      issue(1, 1'b1, 0, 32'hFF, 4'h0, 1'b1);
      wait_done(1);
      issue(1, 1'b0, 0, 32'h0, 4'h0, 1'b1);
      wait_done(1);

      // Randomised mix across all instances, with occasional back-to-back pairs.
      for (int n = 0; n < 300; n++) begin
         int k;
         int gap;
         k = $urandom_range(0, 4);
         if (k == 4 && $urandom_range(0, 3) != 0) k = $urandom_range(0, 3);
         issue(k, 1'($urandom), $urandom_range(0, 31), $urandom, 4'($urandom), 1'b1);
         if ($urandom_range(0, 2) == 0) begin
            to_ack_cycle(k);
            issue(k, 1'($urandom), $urandom_range(0, 31), $urandom, 4'($urandom), 1'b1);
         end
         wait_done(k);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end

      repeat (20) @(posedge clk);
      #1;
      chk("scoreboard_drained", 0, 32'(sbq.size()), 32'd0, 32'hFFFF_FFFF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
